// File: rtl/hs32_ahb_sram.sv
// AHB-lite responder for a single-port synchronous 32-bit SRAM.
// Zero-wait reads/writes, one wait state on write->read port conflict.
module hs32_ahb_sram #(
  parameter int AW        = 10,
  parameter bit READ_ONLY = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          HSEL_i,
  input  logic [31:0]   HADDR_i,
  input  logic          HWRITE_i,
  input  logic [2:0]    HSIZE_i,
  input  logic [2:0]    HBURST_i,
  input  logic [3:0]    HPROT_i,
  input  logic [1:0]    HTRANS_i,
  input  logic          HMASTLOCK_i,
  input  logic          HREADY_i,
  input  logic [31:0]   HWDATA_i,
  output logic          HREADYOUT_o,
  output logic          HRESP_o,
  output logic [31:0]   HRDATA_o,
  output logic          sram_ce_o,
  output logic          sram_we_o,
  output logic [3:0]    sram_be_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, WR_DP, RD_DP, RD_WAIT, ERR1, ERR2
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [3:0]    be_nxt;
  logic          accept;
  logic          illegal;
  logic          rd_now;
  logic          port_wr;
  logic          port_rdq;

  logic unused_ok;
  assign unused_ok = ^{HBURST_i, HPROT_i, HMASTLOCK_i, HTRANS_i[0]};

  assign accept = HSEL_i & HREADY_i & HTRANS_i[1];

  assign illegal = (HSIZE_i > 3'd2)
                 | ((HSIZE_i == 3'd1) & HADDR_i[0])
                 | ((HSIZE_i == 3'd2) & (HADDR_i[1:0] != 2'b00))
                 | (|HADDR_i[31:AW+2])
                 | (HWRITE_i & READ_ONLY);

  always_comb begin
    be_nxt = 4'hF;
    unique case (1'b1)
      HSIZE_i == 3'd0: be_nxt = 4'b0001 << HADDR_i[1:0];
      HSIZE_i == 3'd1: be_nxt = HADDR_i[1] ? 4'b1100 : 4'b0011;
      default:         be_nxt = 4'hF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      be_q   <= '0;
    end else if (state == RD_WAIT) begin
      state <= RD_DP;
    end else if (state == ERR1) begin
      state <= ERR2;
    end else if (accept) begin
      if (illegal) begin
        state <= ERR1;
      end else if (HWRITE_i) begin
        state  <= WR_DP;
        addr_q <= HADDR_i[AW+1:2];
        be_q   <= be_nxt;
      end else if (state == WR_DP) begin
        // port is busy with the pending write; replay the read next cycle
        state  <= RD_WAIT;
        addr_q <= HADDR_i[AW+1:2];
      end else begin
        state <= RD_DP;
      end
    end else if (state != IDLE) begin
      state <= IDLE;
    end
  end

  // reset gating keeps strobes low even while the address phase is live
  assign port_wr  = (state == WR_DP) & ~reset;
  assign port_rdq = (state == RD_WAIT) & ~reset;
  assign rd_now   = accept & ~illegal & ~HWRITE_i
                  & (state != WR_DP) & ~reset;

  assign sram_ce_o    = port_wr | port_rdq | rd_now;
  assign sram_we_o    = port_wr;
  assign sram_be_o    = port_wr ? be_q : 4'h0;
  assign sram_addr_o  = (state == WR_DP || state == RD_WAIT)
                      ? addr_q : HADDR_i[AW+1:2];
  assign sram_wdata_o = HWDATA_i;

  assign HREADYOUT_o = ~(state == RD_WAIT || state == ERR1);
  assign HRESP_o     = (state == ERR1) || (state == ERR2);
  assign HRDATA_o    = (state == RD_DP) ? sram_rdata_i : 32'h0;

endmodule
